// File: rtl/stimulus_response_sequencer.sv
// Exhaustive pattern sequencer: drives every N value to a DUT, lets each settle,
// captures the response bit and compares it against a golden vector.
module stimulus_response_sequencer #(
    parameter int N_WIDTH       = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                      CK,
    input  logic                      reset,
    input  logic                      start,
    input  logic [(2**N_WIDTH)-1:0]   golden,
    input  logic                      output_single,
    output logic [N_WIDTH-1:0]        N,
    output logic                      busy,
    output logic                      done,
    output logic [(2**N_WIDTH)-1:0]   resp_vec,
    output logic                      mismatch,
    output logic [N_WIDTH:0]          mismatch_cnt
);

    localparam int P = 2 ** N_WIDTH;
    localparam logic [N_WIDTH-1:0] IDX_LAST  = N_WIDTH'(P - 1);
    localparam logic [N_WIDTH:0]   CNT_MAX   = (N_WIDTH + 1)'(P);
    localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [N_WIDTH-1:0]   idx_q, idx_d;
    logic [N_WIDTH-1:0]   n_q, n_d;
    logic [3:0]           settle_q, settle_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [P-1:0]         resp_q, resp_d;
    logic                 mm_q, mm_d;
    logic [N_WIDTH:0]     mmc_q, mmc_d;

    // N carries the pattern value bit-reversed: N[0] is the pattern MSB.
    function automatic logic [N_WIDTH-1:0] rev_f(input logic [N_WIDTH-1:0] v);
        logic [N_WIDTH-1:0] r;
        for (int i = 0; i < N_WIDTH; i++) begin
            r[i] = v[N_WIDTH-1-i];
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = done_q;
        resp_d   = resp_q;
        mm_d     = mm_q;
        mmc_d    = mmc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SETTLE;
                    idx_d    = '0;
                    n_d      = '0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    resp_d   = '0;
                    mm_d     = 1'b0;
                    mmc_d    = '0;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CAPTURE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            CAPTURE: begin
                resp_d[idx_q] = output_single;
                if (output_single != golden[idx_q]) begin
                    mm_d = 1'b1;
                    if (mmc_q != CNT_MAX) begin
                        mmc_d = mmc_q + 1'b1;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    n_d     = rev_f(idx_q + 1'b1);
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            n_q      <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            resp_q   <= '0;
            mm_q     <= 1'b0;
            mmc_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            resp_q   <= resp_d;
            mm_q     <= mm_d;
            mmc_q    <= mmc_d;
        end
    end

    assign N            = n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign resp_vec     = resp_q;
    assign mismatch     = mm_q;
    assign mismatch_cnt = mmc_q;

endmodule

// File: tb/tb_stimulus_response_sequencer.sv
// Randomized bench for stimulus_response_sequencer: two instances (settle 1 and 3)
// share start/reset/golden and are compared cycle by cycle against a timing model.
module tb_stimulus_response_sequencer;

    logic       CK = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] golden;
    logic [3:0] resp_tbl;

    logic [1:0] na, nb;
    logic       busy_a, busy_b, done_a, done_b, mm_a, mm_b, os_a, os_b;
    logic [3:0] resp_a, resp_b;
    logic [2:0] mmc_a, mmc_b;

    int checks = 0;
    int failures = 0;

    always #5 CK = ~CK;

    function automatic logic [1:0] rev2(input logic [1:0] v);
        return {v[0], v[1]};
    endfunction

    // The simulated DUT answers with resp_tbl indexed by the pattern value.
    assign os_a = resp_tbl[rev2(na)];
    assign os_b = resp_tbl[rev2(nb)];

    stimulus_response_sequencer #(.N_WIDTH(2), .SETTLE_CYCLES(1)) u_a (
        .CK(CK), .reset(reset), .start(start), .golden(golden),
        .output_single(os_a), .N(na), .busy(busy_a), .done(done_a),
        .resp_vec(resp_a), .mismatch(mm_a), .mismatch_cnt(mmc_a)
    );

    stimulus_response_sequencer #(.N_WIDTH(2), .SETTLE_CYCLES(3)) u_b (
        .CK(CK), .reset(reset), .start(start), .golden(golden),
        .output_single(os_b), .N(nb), .busy(busy_b), .done(done_b),
        .resp_vec(resp_b), .mismatch(mm_b), .mismatch_cnt(mmc_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".a.N"}, 32'(na), 0);
        chk({tag, ".a.busy"}, 32'(busy_a), 0);
        chk({tag, ".a.done"}, 32'(done_a), 0);
        chk({tag, ".a.resp"}, 32'(resp_a), 0);
        chk({tag, ".a.mm"}, 32'(mm_a), 0);
        chk({tag, ".a.mmc"}, 32'(mmc_a), 0);
        chk({tag, ".b.N"}, 32'(nb), 0);
        chk({tag, ".b.busy"}, 32'(busy_b), 0);
        chk({tag, ".b.done"}, 32'(done_b), 0);
        chk({tag, ".b.resp"}, 32'(resp_b), 0);
        chk({tag, ".b.mmc"}, 32'(mmc_b), 0);
    endtask

    // Expected outputs cyc edges after the start edge, for settle length s.
    task automatic model_chk(input string tag, input int s, input int cyc,
                             input logic [1:0] n, input logic bsy,
                             input logic dn, input logic [3:0] rv,
                             input logic mm, input logic [2:0] mmc);
        int per, c, pat, cnt;
        logic [3:0] mask;
        per  = s + 1;
        c    = (cyc / per > 4) ? 4 : cyc / per;
        pat  = (c == 4) ? 3 : c;
        mask = 4'((1 << c) - 1);
        cnt  = $countones((resp_tbl ^ golden) & mask);
        chk({tag, ".N"}, 32'(n), 32'(rev2(2'(pat))));
        chk({tag, ".busy"}, 32'(bsy), 32'(c < 4));
        chk({tag, ".done"}, 32'(dn), 32'(c == 4));
        chk({tag, ".resp"}, 32'(rv), 32'(resp_tbl & mask));
        chk({tag, ".mm"}, 32'(mm), 32'(cnt != 0));
        chk({tag, ".mmc"}, 32'(mmc), 32'(cnt));
    endtask

    task automatic run(input int mode, input int spur, input int rst_at);
        case (mode)
            0: begin golden = 4'b0110; resp_tbl = 4'b0110; end
            1: begin golden = 4'b0110; resp_tbl = 4'b1110; end
            2: begin golden = 4'($urandom); resp_tbl = ~golden; end
            default: begin golden = 4'($urandom); resp_tbl = 4'($urandom); end
        endcase
        @(negedge CK);
        start = 1'b1;
        @(posedge CK);
        #1;
        model_chk("c0.a", 1, 0, na, busy_a, done_a, resp_a, mm_a, mmc_a);
        model_chk("c0.b", 3, 0, nb, busy_b, done_b, resp_b, mm_b, mmc_b);
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge CK);
            start = (cyc == spur);
            if (cyc == rst_at) reset = 1'b1;
            @(posedge CK);
            #1;
            if (cyc == rst_at) begin
                chk_idle("abort");
                @(negedge CK);
                reset = 1'b0;
                start = 1'b0;
                @(posedge CK);
                #1;
                chk_idle("post_abort");
                return;
            end
            model_chk("run.a", 1, cyc, na, busy_a, done_a, resp_a, mm_a, mmc_a);
            model_chk("run.b", 3, cyc, nb, busy_b, done_b, resp_b, mm_b, mmc_b);
        end
        @(negedge CK);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        golden = 4'b0110;
        resp_tbl = 4'b0110;
        repeat (2) @(posedge CK);
        #1;
        chk_idle("reset");
        @(negedge CK);
        start = 1'b1;
        @(posedge CK);
        #1;
        chk_idle("rst_start");
        @(negedge CK);
        reset = 1'b0;
        start = 1'b0;
        @(posedge CK);
        #1;
        chk_idle("idle_hold");

        run(0, -1, -1);
        run(1, -1, -1);
        run(2, -1, -1);
        run(2, -1, -1);
        run(0, 3, -1);
        run(3, -1, 5);
        run(0, -1, -1);
        for (int i = 0; i < 20; i++) begin
            run(int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : -1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
